// File: rtl/button_shaper_multi.sv
// Multi-channel push-button shaper: 2-flop sync, debounce FSM, one-cycle press pulse and held level.
// Optional auto-repeat while held is enabled by defining BUTTON_SHAPER_REPEAT_EN.
module button_shaper_multi #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned DEB_CYCLES    = 4,
  parameter int unsigned REPEAT_DELAY  = 16,
  parameter int unsigned REPEAT_PERIOD = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [NUM_CH-1:0] B,
  output logic [NUM_CH-1:0] B_Out,
  output logic [NUM_CH-1:0] B_Held,
  output logic              B_Any
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    PULSE    = 3'd2,
    HELD     = 3'd3,
    REL_DB   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
`ifdef BUTTON_SHAPER_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

  logic [NUM_CH-1:0] r_sync1;
  logic [NUM_CH-1:0] r_sync2;

  // Reset to all-ones so a held button is seen as released until resampled
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= B;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_s;
`ifdef BUTTON_SHAPER_REPEAT_EN
    logic             r_rep_phase;
    logic             w_rep_phase_nxt;
`endif

    assign w_s = r_sync2[g];

    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        r_state     <= IDLE;
        r_cnt       <= '0;
`ifdef BUTTON_SHAPER_REPEAT_EN
        r_rep_phase <= 1'b0;
`endif
      end else begin
        r_state     <= w_next;
        r_cnt       <= w_cnt_nxt;
`ifdef BUTTON_SHAPER_REPEAT_EN
        r_rep_phase <= w_rep_phase_nxt;
`endif
      end
    end

    // Next state; counter is compared before incrementing so it never wraps
    always_comb begin
      w_next    = r_state;
      w_cnt_nxt = r_cnt;
`ifdef BUTTON_SHAPER_REPEAT_EN
      w_rep_phase_nxt = r_rep_phase;
`endif
      case (r_state)
        IDLE: begin
          if (!w_s) begin
            w_next    = PRESS_DB;
            w_cnt_nxt = '0;
          end
        end
        PRESS_DB: begin
          if (w_s)                   w_next    = IDLE;
          else if (r_cnt == DEB_LAST) w_next   = PULSE;
          else                        w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        PULSE: begin
          w_next    = HELD;
          w_cnt_nxt = '0;
        end
        HELD: begin
          if (w_s) begin
            w_next    = REL_DB;
            w_cnt_nxt = '0;
          end
`ifdef BUTTON_SHAPER_REPEAT_EN
          else if (r_cnt == (r_rep_phase ? RPT_PER_LAST : RPT_DLY_LAST)) begin
            w_next          = PULSE;
            w_rep_phase_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
`endif
        end
        REL_DB: begin
          if (!w_s) begin
            w_next    = HELD;
            w_cnt_nxt = '0;
          end else if (r_cnt == DEB_LAST) begin
            w_next = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_next    = IDLE;
          w_cnt_nxt = '0;
        end
      endcase
`ifdef BUTTON_SHAPER_REPEAT_EN
      if (w_next == IDLE) w_rep_phase_nxt = 1'b0;
`endif
    end

    assign B_Out[g]  = (r_state == PULSE);
    assign B_Held[g] = (r_state == HELD) || (r_state == REL_DB);
  end

  assign B_Any = |B_Out;

endmodule

// File: tb/tb_button_shaper_multi.sv
// Bench for button_shaper_multi: run-length debounce model checked every cycle plus directed literal checks.
module tb_button_shaper_multi;
  localparam int unsigned NCH    = 4;
  localparam int unsigned DEB    = 4;
  localparam int unsigned RDELAY = 16;
  localparam int unsigned RPER   = 4;

  logic           Clk;
  logic           Rst;
  logic [NCH-1:0] B;
  logic [NCH-1:0] B_Out;
  logic [NCH-1:0] B_Held;
  logic           B_Any;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  button_shaper_multi #(
    .NUM_CH(NCH), .DEB_CYCLES(DEB), .REPEAT_DELAY(RDELAY), .REPEAT_PERIOD(RPER), .CNT_W(8)
  ) dut (
    .Clk(Clk), .Rst(Rst), .B(B), .B_Out(B_Out), .B_Held(B_Held), .B_Any(B_Any)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Model: a press/release is accepted after DEB+1 consecutive agreeing synchronised samples;
  // the pulse cycle ignores the input; repeats fire after a count of quiet held samples.
  logic [NCH-1:0] m_s1, m_s2, m_sv;
  int m_run[NCH];
  int m_rep[NCH];
  bit m_db[NCH];
  bit m_skip[NCH];
  bit m_out[NCH];
  bit m_ph[NCH];

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      m_s1 = '1;
      m_s2 = '1;
      for (int i = 0; i < NCH; i++) begin
        m_run[i] = 0; m_rep[i] = 0; m_db[i] = 0; m_skip[i] = 0; m_out[i] = 0; m_ph[i] = 0;
      end
    end else begin
      m_sv = m_s2;
      m_s2 = m_s1;
      m_s1 = B;
      for (int i = 0; i < NCH; i++) begin
        m_out[i] = 0;
        if (m_skip[i]) begin
          m_skip[i] = 0; m_db[i] = 1; m_rep[i] = 0; m_run[i] = 0;
        end else if (!m_db[i]) begin
          if (m_sv[i] == 1'b0) begin
            m_run[i]++;
            if (m_run[i] == DEB + 1) begin
              m_out[i] = 1; m_skip[i] = 1; m_run[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end else begin
          if (m_sv[i] == 1'b1) begin
            m_run[i]++;
            m_rep[i] = 0;
            if (m_run[i] == DEB + 1) begin
              m_db[i] = 0; m_run[i] = 0; m_ph[i] = 0;
            end
          end else if (m_run[i] > 0) begin
            m_run[i] = 0;
            m_rep[i] = 0;
          end else begin
`ifdef BUTTON_SHAPER_REPEAT_EN
            m_rep[i]++;
            if (m_rep[i] == (m_ph[i] ? RPER : RDELAY)) begin
              m_out[i] = 1; m_skip[i] = 1; m_rep[i] = 0; m_ph[i] = 1;
            end
`endif
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge Clk) begin
    logic [NCH-1:0] eo, eh;
    if (started) begin
      for (int i = 0; i < NCH; i++) begin
        eo[i] = m_out[i];
        eh[i] = m_db[i] & ~m_skip[i];
      end
      chk("model_out", B_Out, eo);
      chk("model_held", B_Held, eh);
      chk("model_any", NCH'(B_Any), NCH'(|eo));
    end
  end

  int pcnt[NCH];
  always @(negedge Clk) begin
    for (int i = 0; i < NCH; i++) if (B_Out[i] === 1'b1) pcnt[i]++;
  end

  int snap;

  initial begin
    B   = '1;
    Rst = 1'b0;
    #3 Rst = 1'b1;
    #1 started = 1;
    chk("rst_imm_out", B_Out, '0);
    chk("rst_imm_held", B_Held, '0);
    chk("rst_imm_any", NCH'(B_Any), '0);
    repeat (2) @(posedge Clk);
    @(negedge Clk) Rst = 1'b0;
    step(20);
    chk("idle20_out", B_Out, '0);
    chk("idle20_held", B_Held, '0);

    // Clean press on channel 0
    snap = pcnt[0];
    @(negedge Clk) B[0] = 1'b0;
    step(6);
    chk("press_e5_out", B_Out, 4'b0000);
    step(1);
    chk("press_e6_out", B_Out, 4'b0001);
    chk("press_e6_held", B_Held, 4'b0000);
    step(1);
    chk("press_e7_out", B_Out, 4'b0000);
    chk("press_e7_held", B_Held, 4'b0001);
`ifdef BUTTON_SHAPER_REPEAT_EN
    step(16);
    chk("rep_e23_out", B_Out, 4'b0001);
    step(5);
    chk("rep_e28_out", B_Out, 4'b0001);
    step(2);
`else
    step(23);
    chk("hold_e30_out", B_Out, 4'b0000);
    chk("hold_e30_held", B_Held, 4'b0001);
    chk("hold_one_pulse", NCH'(pcnt[0] - snap), NCH'(1));
`endif

    // Release with a one-cycle low glitch inside release debounce
    snap = pcnt[0];
    @(negedge Clk) B[0] = 1'b1;
    step(2);
    B[0] = 1'b0;
    step(1);
    B[0] = 1'b1;
    step(6);
    chk("rel_e8_held", B_Held, 4'b0001);
    step(1);
    chk("rel_e9_held", B_Held, 4'b0000);
    chk("rel_no_pulse", NCH'(pcnt[0] - snap), '0);

    // Bouncing channel 1 never qualifies
    snap = pcnt[1];
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < 3; j++)
        @(negedge Clk) B[1] = (j == 2);
    step(10);
    chk("bounce_held", B_Held, 4'b0000);
    chk("bounce_no_pulse", NCH'(pcnt[1] - snap), '0);

    // Simultaneous press on channels 2 and 3
    @(negedge Clk) B[3:2] = 2'b00;
    step(7);
    chk("dual_e6_out", B_Out, 4'b1100);
    chk("dual_e6_any", NCH'(B_Any), NCH'(1));
    step(1);
    chk("dual_e7_out", B_Out, 4'b0000);
    chk("dual_e7_any", NCH'(B_Any), '0);
    chk("dual_e7_held", B_Held, 4'b1100);
    @(negedge Clk) B = '1;
    step(10);
    chk("dual_rel_held", B_Held, 4'b0000);

    // Reset mid-hold, then a fresh debounce is required
    @(negedge Clk) B[0] = 1'b0;
    step(10);
    chk("midrst_pre_held", B_Held, 4'b0001);
    #3 Rst = 1'b1;
    #1;
    chk("midrst_out", B_Out, '0);
    chk("midrst_held", B_Held, '0);
    step(3);
    @(negedge Clk) Rst = 1'b0;
    step(6);
    chk("post_rst_e5_out", B_Out, 4'b0000);
    step(1);
    chk("post_rst_e6_out", B_Out, 4'b0001);
    @(negedge Clk) B = '1;
    step(15);
    chk("final_held", B_Held, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
